// File: rtl/gray_to_binary.sv
// Registered Gray-to-binary converter with an optional adjacency checker.
// Optional feature macro: GRAY_TO_BINARY_STEP_CHECK_EN (enables step_err history check).
module gray_to_binary #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray,
    output logic             out_valid,
    output logic [WIDTH-1:0] binary,
    output logic             step_err
);

    logic [WIDTH-1:0] bin_c;

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        bin_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_c[i] = ^(gray >> i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            binary    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                binary <= bin_c;
            end
        end
    end

`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic             have_prev;
    logic             multi_bit;

    always_comb begin
        multi_bit = ($countones(gray ^ prev_gray) > 1);
    end

    // The first accepted word after reset has no predecessor to compare against.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray <= '0;
            have_prev <= 1'b0;
            step_err  <= 1'b0;
        end else if (in_valid) begin
            prev_gray <= gray;
            have_prev <= 1'b1;
            step_err  <= have_prev & multi_bit;
        end
    end
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary.sv
// Randomized and directed bench for gray_to_binary against a lookup-table reference.
module tb_gray_to_binary;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] gray;
    logic             out_valid;
    logic [WIDTH-1:0] binary;
    logic             step_err;

    int checks = 0;
    int errors = 0;

    // Reference: invert the forward encoding n -> n ^ (n >> 1).
    int lut [256];

    // Model state
    logic             exp_valid;
    logic [WIDTH-1:0] exp_bin;
    logic             exp_err;
    logic [WIDTH-1:0] m_prev;
    logic             m_have;

    gray_to_binary #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .gray      (gray),
        .out_valid (out_valid),
        .binary    (binary),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int popcount8(input logic [WIDTH-1:0] v);
        int c = 0;
        for (int k = 0; k < WIDTH; k++) c += int'(v[k]);
        return c;
    endfunction

    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] g);
        rst      = r;
        in_valid = v;
        gray     = g;
        @(posedge clk);
        if (r) begin
            exp_valid = 1'b0;
            exp_bin   = '0;
            exp_err   = 1'b0;
            m_have    = 1'b0;
            m_prev    = '0;
        end else begin
            exp_valid = v;
            if (v) begin
                exp_bin = WIDTH'(lut[g]);
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
                exp_err = m_have && (popcount8(g ^ m_prev) > 1);
`else
                exp_err = 1'b0;
`endif
                m_prev = g;
                m_have = 1'b1;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("binary", 32'(binary), 32'(exp_bin));
        check("step_err", 32'(step_err), 32'(exp_err));
    endtask

    initial begin
        logic [WIDTH-1:0] dir_a [5];
        logic [WIDTH-1:0] dir_b [3];
        logic [WIDTH-1:0] seq_c [3];

        for (int n = 0; n < 256; n++) lut[n ^ (n >> 1)] = n;
        exp_valid = 0; exp_bin = 0; exp_err = 0; m_prev = 0; m_have = 0;
        rst = 1'b1; in_valid = 1'b0; gray = '0;

        // Reset state
        step(1, 0, 8'h00);
        step(1, 1, 8'h5a);

        dir_a = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h04};
        foreach (dir_a[i]) step(0, 1, dir_a[i]);

        dir_b = '{8'h08, 8'h0e, 8'h80};
        foreach (dir_b[i]) step(0, 1, dir_b[i]);
        check("wrap_max", 32'(binary), 32'hff);

        // Single pulse then idle: value held, valid low
        step(0, 1, 8'h05);
        check("pulse_val", 32'(binary), 32'h06);
        for (int i = 0; i < 3; i++) step(0, 0, 8'($urandom));

        // Reset wins over simultaneous valid
        step(1, 1, 8'h0d);
        check("rst_prio", 32'(binary), 32'h00);

        seq_c = '{8'h00, 8'h01, 8'h07};
        foreach (seq_c[i]) step(0, 1, seq_c[i]);
`ifdef GRAY_TO_BINARY_STEP_CHECK_EN
        check("jump_err", 32'(step_err), 32'h1);
`endif
        step(1, 0, 8'h00);
        step(0, 1, 8'h80);
        step(0, 1, 8'h00);
        check("zero_conv", 32'(binary), 32'h00);

        // Exhaustive sweep
        step(1, 0, 8'h00);
        for (int n = 0; n < 256; n++) step(0, 1, 8'(n));

        // Random stream with idles, occasional mid-stream reset, and mostly
        // single-bit walks so both legal and illegal steps occur.
        for (int i = 0; i < 1500; i++) begin
            logic [WIDTH-1:0] g;
            int sel = $urandom_range(0, 9);
            if (sel < 6) g = m_prev ^ (8'h01 << $urandom_range(0, WIDTH - 1));
            else if (sel < 7) g = m_prev;
            else g = 8'($urandom);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_to_binary.md
GRAY_TO_BINARY -- requirements
Module: gray_to_binary

Interface
REQ-001 Parameter WIDTH, default 8: gray/binary word width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  qualifies gray for the current cycle.
REQ-005 gray  input  WIDTH  reflected-binary Gray code input word.
REQ-006 out_valid  output  1  qualifies binary and step_err.
REQ-007 binary  output  WIDTH  converted natural-binary word, registered.
REQ-008 step_err  output  1  adjacency-violation flag, registered; see Configuration.

Function
REQ-009 Conversion SHALL be: binary[WIDTH-1] = gray[WIDTH-1]; binary[i] = binary[i+1] XOR gray[i] for i = WIDTH-2 down to 0.
REQ-010 Latency SHALL be exactly one clock: a sample accepted at edge N (in_valid=1) appears on binary with out_valid=1 after edge N.
REQ-011 out_valid SHALL equal in_valid registered one cycle; every accepted sample yields exactly one out_valid cycle; no backpressure.
REQ-012 When in_valid=0, binary and step_err SHALL hold their last values and out_valid SHALL be 0.
REQ-013 Back-to-back in_valid=1 SHALL give one result per cycle, full throughput.
REQ-014 Conversion is combinational on gray before the output register; no carry chain beyond the XOR prefix, no truncation; all WIDTH bits are significant.
REQ-015 Wrap-around: gray pattern 1 followed by WIDTH-1 zeros SHALL convert to all ones (max count), and the all-zero gray word SHALL convert to zero.

Reset
REQ-016 When rst=1 at a rising edge: out_valid=0, binary=0, step_err=0, previous-sample history cleared, regardless of in_valid.
REQ-017 rst SHALL take priority over a simultaneous in_valid=1; that sample is discarded and produces no output.
REQ-018 Reset mid-stream SHALL drop any in-flight result; the first valid sample after reset is treated as the first sample ever.

Configuration
REQ-019 Macro GRAY_TO_BINARY_STEP_CHECK_EN SHALL control the adjacency checker.
REQ-020 With the macro defined: the block stores the previous accepted gray word; for each accepted sample after the first since reset, step_err SHALL be 1 (aligned with its out_valid) when the word differs from the previous accepted word in more than one bit, else 0; identical words and single-bit changes are legal; the first sample after reset SHALL give step_err=0.
REQ-021 Without the macro: no history register exists, step_err SHALL be constant 0, and conversion behaviour is unchanged.

Verification
REQ-022 Reset then in_valid=1 with gray 00000000, 00000001, 00000011, 00000010, 00000100 -> next cycles binary 00000000, 00000001, 00000010, 00000011, 00000111, out_valid=1 each cycle.
REQ-023 gray 00001000 -> binary 00001111; gray 00001110 -> 00001011; gray 10000000 -> 11111111 (WIDTH=8).
REQ-024 in_valid pulse with gray 00000101, then in_valid=0 for 3 cycles -> binary 00000110 for one out_valid cycle, then held with out_valid=0.
REQ-025 in_valid=1 with gray 00001101 in the same cycle as rst=1 -> out_valid=0, binary=00000000 next cycle.
REQ-026 With GRAY_TO_BINARY_STEP_CHECK_EN: sequence 00000000, 00000001, 00000111 -> step_err 0, 0, 1; then 10000000 after reset, then 00000000 -> step_err 0, 0 (wrap is legal).
REQ-027 Exhaustive sweep over all 256 gray words (both macro settings) -> binary equals the REQ-009 reference, one cycle later.
